decrypt_round_sequencer: RTL and testbench
==========================================

// Module: decrypt_round_sequencer
// PURPOSE
//  Round controller for the decrypt path: the inverse of the encrypt-side up-counting round counter.
//  Steps key rounds NUM_ROUNDS down to 1 and emits the right-rotate amount the key schedule needs for each round.
//  Uses a start/busy/done handshake.
//  Sits between the USB packet controller (start/abort) and the DES decrypt datapath + key register (strobes).
// PARAMETERS
//  NUM_ROUNDS  16  number of cipher rounds; key_round counts NUM_ROUNDS..1
//  CNT_W       5   width of key_round; must satisfy 2**CNT_W > NUM_ROUNDS
// PORTS
//  clk          in   1      clock, rising edge
//  n_rst        in   1      asynchronous, active-low reset
//  start        in   1      request a new block; sampled only in IDLE
//  step_en      in   1      datapath ready to execute a round; low = stall
//  abort        in   1      synchronous cancel, highest priority after reset
//  busy         out  1      high in LOAD, ROUND, FINISH
//  load_data    out  1      one-cycle pulse: latch ciphertext block + reload key reg (C0D0)
//  round_strobe out  1      datapath executes round key_round this cycle
//  key_round    out  CNT_W  current key index K[key_round]
//  key_rot_amt  out  2      right-rotate C/D by this amount before using K[key_round]
//  done         out  1      one-cycle pulse: plaintext valid in datapath
// BEHAVIOUR
//  Reset:
//  - state=IDLE, key_round=0, all 1-bit outputs 0, key_rot_amt=0.
//  FSM states and transitions:
//  - IDLE -> LOAD on start.
//  - LOAD -> ROUND unconditionally, after 1 cycle; key_round<=NUM_ROUNDS on entry.
//  - ROUND: on each cycle with step_en=1, round_strobe=1.
//    - If key_round==1: -> FINISH.
//    - Else: key_round<=key_round-1.
//    - step_en=0: hold state and key_round; round_strobe=0.
//  - FINISH -> IDLE, after 1 cycle; key_round<=0 on exit.
//  Output decode:
//  - busy, load_data (LOAD) and done (FINISH) are Moore decodes of state.
//  - round_strobe = (state==ROUND) & step_en. It is the only combinational input->output path.
//  Latency (step_en held 1): start sampled in cycle 0.
//  - LOAD: cycle 1.
//  - Strobes: cycles 2..NUM_ROUNDS+1.
//  - done: cycle NUM_ROUNDS+2.
//  - IDLE: cycle NUM_ROUNDS+3.
//  key_rot_amt, combinational from key_round (0 outside ROUND):
//  - key_round==NUM_ROUNDS -> 0 (K16 == C0D0).
//  - Otherwise -> ENC_SHIFT[key_round+1], where ENC_SHIFT[r] = 1 for r in {1,2,9,16}, else 2.
//  - Resulting decrypt order for r=16..1: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27 = net left 1).
//  Boundaries:
//  - start while busy: ignored, not queued.
//  - start and abort in the same IDLE cycle: abort wins, stay IDLE.
//  - abort in any state: next cycle IDLE, key_round=0, no done, no further strobe.
//    round_strobe still follows step_en in the abort cycle itself.
//  - step_en low in LOAD/FINISH: no effect.
//  - key_round never wraps below 1 in ROUND; the decrement at 1 is suppressed.
//  - n_rst low mid-run: immediate IDLE, all outputs to reset values.
// STRUCTURE
//  - Package des_round_pkg: NUM_ROUNDS_DES=16, typedef round_idx_t logic[4:0],
//    enum dec_state_t {IDLE, LOAD, ROUND, FINISH}, function enc_shift(round_idx_t) -> logic[1:0].
//  - Encrypt-side counter shares this package.
//  - Sub-module dec_key_rot_lut: combinational key_round -> key_rot_amt, reusable by key schedule.
//  - Remainder is one FSM + one down-counter register.
// TESTING
//  1. Reset values: n_rst=0 -> busy=0, load_data=0, round_strobe=0, done=0, key_round=0, key_rot_amt=0.
//  2. Full run, step_en=1, start pulse cycle 0 -> load_data cycle 1.
//     Then strobes cycles 2..17 with key_round 16..1 and key_rot_amt 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//     Then done cycle 18 only; busy cycles 1..18.
//  3. Stall: step_en=0 for 3 cycles when key_round=10 -> key_round stays 10, no strobes.
//     Resumes 10,9..1; done 3 cycles late (cycle 21).
//  4. Abort at key_round=5 -> next cycle IDLE, key_round=0, busy=0.
//     done never pulses; a fresh start then gives a complete run as in 2.
//  5. start pulsed at key_round=12 and in FINISH -> ignored; exactly one done.
//     start in same cycle as abort from IDLE -> stays IDLE.
//  6. n_rst asserted at key_round=7 -> outputs at reset values asynchronously.
//     After release + start, run matches 2.

Source files
------------

// File: rtl/des_round_pkg.sv
// Shared DES round definitions for the encrypt-side and decrypt-side round controllers.
package des_round_pkg;

    localparam int NUM_ROUNDS_DES = 16;

    typedef logic [4:0] round_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        FINISH
    } dec_state_t;

    // Left-shift amount the encrypt key schedule applies before round r.
    function automatic logic [1:0] enc_shift(input round_idx_t r);
        case (r)
            5'd1, 5'd2, 5'd9, 5'd16: return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/dec_key_rot_lut.sv
// Maps a decrypt key index to the right-rotate the key register needs before
// that round. Decrypt undoes the encrypt shift of the *following* round; round
// NUM_ROUNDS needs no rotate because K16 is formed from C0D0 itself.
module dec_key_rot_lut
    import des_round_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DES,
    parameter int CNT_W      = 5
) (
    input  logic             active,
    input  logic [CNT_W-1:0] key_round,
    output logic [1:0]       key_rot_amt
);

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

    logic [CNT_W-1:0] next_round;

    assign next_round = key_round + CNT_W'(1);

    // Rotate is forced to zero outside active rounds so the key register holds.
    always_comb begin
        key_rot_amt = 2'd0;
        if (active && (key_round != LAST_ROUND)) begin
            key_rot_amt = enc_shift(round_idx_t'(next_round));
        end
    end

endmodule

// File: rtl/decrypt_round_sequencer.sv
// Decrypt-path round controller: loads a block, walks key rounds NUM_ROUNDS
// down to 1 (stalling on step_en), then signals done. Abort cancels at any point.
module decrypt_round_sequencer
    import des_round_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DES,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             step_en,
    input  logic             abort,
    output logic             busy,
    output logic             load_data,
    output logic             round_strobe,
    output logic [CNT_W-1:0] key_round,
    output logic [1:0]       key_rot_amt,
    output logic             done
);

    localparam logic [CNT_W-1:0] FIRST_ROUND = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST_ROUND  = CNT_W'(1);

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [CNT_W-1:0] key_round_nxt;

    // State and round-counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            key_round <= '0;
        end else begin
            state     <= state_nxt;
            key_round <= key_round_nxt;
        end
    end

    // Next-state, counter update and output decode; abort overrides everything.
    always_comb begin
        state_nxt     = state;
        key_round_nxt = key_round;
        busy          = 1'b0;
        load_data     = 1'b0;
        round_strobe  = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                busy          = 1'b1;
                load_data     = 1'b1;
                state_nxt     = ROUND;
                key_round_nxt = FIRST_ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (step_en) begin
                    round_strobe = 1'b1;
                    // Counter parks at 1 on the last round rather than wrapping.
                    if (key_round == LAST_ROUND) state_nxt = FINISH;
                    else                         key_round_nxt = key_round - CNT_W'(1);
                end
            end
            FINISH: begin
                busy          = 1'b1;
                done          = 1'b1;
                state_nxt     = IDLE;
                key_round_nxt = '0;
            end
            default: begin
                state_nxt     = IDLE;
                key_round_nxt = '0;
            end
        endcase
        if (abort) begin
            state_nxt     = IDLE;
            key_round_nxt = '0;
        end
    end

    dec_key_rot_lut #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .CNT_W      (CNT_W)
    ) u_rot_lut (
        .active      (state == ROUND),
        .key_round   (key_round),
        .key_rot_amt (key_rot_amt)
    );

endmodule

// File: tb/tb_decrypt_round_sequencer.sv
// Scoreboard bench for decrypt_round_sequencer: the stimulus task predicts each
// load/strobe/done event with its cycle number; a negedge monitor checks them.
module tb_decrypt_round_sequencer;

    localparam int EV_LOAD   = 0;
    localparam int EV_STROBE = 1;
    localparam int EV_DONE   = 2;

    typedef struct {
        int cyc;
        int kind;
        int kr;
        int rot;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       step_en;
    logic       abort;
    logic       busy;
    logic       load_data;
    logic       round_strobe;
    logic [4:0] key_round;
    logic [1:0] key_rot_amt;
    logic       done;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t e;

    // Hand-derived decrypt rotate for key rounds 1..16.
    int rot_tab [1:16] = '{1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 0};

    decrypt_round_sequencer #(.NUM_ROUNDS(16), .CNT_W(5)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .step_en      (step_en),
        .abort        (abort),
        .busy         (busy),
        .load_data    (load_data),
        .round_strobe (round_strobe),
        .key_round    (key_round),
        .key_rot_amt  (key_rot_amt),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input int kr, input int rot);
        exp_t x;
        x.cyc  = cyc;
        x.kind = kind;
        x.kr   = kr;
        x.rot  = rot;
        sb.push_back(x);
    endtask

    // Monitor: every visible output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (load_data || round_strobe || done) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_kind", load_data ? EV_LOAD : (round_strobe ? EV_STROBE : EV_DONE), e.kind);
                if (e.kind == EV_STROBE) begin
                    check("key_round", int'(key_round), e.kr);
                    check("key_rot_amt", int'(key_rot_amt), e.rot);
                end
            end
        end
    end

    // One block: optional stall, abort, reset or extra start pulses at given key rounds.
    task automatic do_run(input int stall_kr, input int stall_n, input int abort_kr,
                          input int rst_kr, input bit extra_start);
        int m_kr;
        int stall_left;
        bit ended;
        bit aborted;
        bit resetted;
        @(posedge clk); #1;
        start = 1'b1; step_en = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; step_en = 1'b0;
        push(EV_LOAD, 0, 0);
        check("busy_load", int'(busy), 1);
        m_kr = 16; stall_left = stall_n; ended = 0; aborted = 0; resetted = 0;
        for (int t = 0; t < 40 && !ended; t++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; step_en = 1'b1;
            check("busy_round", int'(busy), 1);
            if (m_kr == rst_kr) begin
                n_rst = 1'b0;
                #1;
                check("rst_busy", int'(busy), 0);
                check("rst_strobe", int'(round_strobe), 0);
                check("rst_key_round", int'(key_round), 0);
                check("rst_rot", int'(key_rot_amt), 0);
                ended = 1; resetted = 1;
            end else if (m_kr == stall_kr && stall_left > 0) begin
                step_en = 1'b0;
                stall_left--;
            end else begin
                push(EV_STROBE, m_kr, rot_tab[m_kr]);
                if (extra_start && m_kr == 12) start = 1'b1;
                if (m_kr == abort_kr) begin
                    abort = 1'b1; ended = 1; aborted = 1;
                end else if (m_kr == 1) begin
                    ended = 1;
                end else begin
                    m_kr--;
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        if (resetted) begin
            check("rst_hold_busy", int'(busy), 0);
            n_rst = 1'b1;
        end else if (aborted) begin
            check("abort_busy", int'(busy), 0);
            check("abort_key_round", int'(key_round), 0);
            check("abort_rot", int'(key_rot_amt), 0);
        end else begin
            push(EV_DONE, 0, 0);
            check("busy_finish", int'(busy), 1);
            check("finish_key_round", int'(key_round), 1);
            step_en = 1'b0;
            if (extra_start) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; step_en = 1'b1;
            check("idle_busy", int'(busy), 0);
            check("idle_key_round", int'(key_round), 0);
        end
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b1; step_en = 1'b1; abort = 1'b0;
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_load", int'(load_data), 0);
        check("reset_strobe", int'(round_strobe), 0);
        check("reset_done", int'(done), 0);
        check("reset_key_round", int'(key_round), 0);
        check("reset_rot", int'(key_rot_amt), 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1; start = 1'b0;

        do_run(0, 0, 0, 0, 1'b0);   // full run
        do_run(10, 3, 0, 0, 1'b0);  // 3-cycle stall at round 10
        do_run(0, 0, 5, 0, 1'b0);   // abort at round 5
        do_run(0, 0, 0, 0, 1'b0);   // clean run after abort
        do_run(0, 0, 0, 0, 1'b1);   // start pulses while busy are ignored

        // start and abort together in IDLE: abort wins.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_load", int'(load_data), 0);
        repeat (3) @(posedge clk);

        do_run(0, 0, 0, 7, 1'b0);   // async reset at round 7
        do_run(0, 0, 0, 0, 1'b0);   // clean run after reset

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
